// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the L1 data cache.
package cache_pkg;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned DEF_NUM_LINES  = 4;

  // Word-offset field width (word index within a line).
  function automatic int unsigned offset_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Line-index field width.
  function automatic int unsigned index_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  // Tag width: whatever is left above offset, index and the byte bits.
  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned line_words,
                                        input int unsigned num_lines);
    return addr_w - offset_w(line_words) - index_w(num_lines) - 2;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVICT = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  // Full cache line for the default configuration, word 0 in the LSBs.
  typedef logic [DEF_LINE_WORDS*DEF_DATA_W-1:0] line_t;

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data arrays: one combinational read port, one synchronous
// write port (single-word store or full-line refill).
module cache_line_store import cache_pkg::*; #(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
  parameter int unsigned TAG_W      = tag_w(DEF_ADDR_W, DEF_LINE_WORDS, DEF_NUM_LINES),
  localparam int unsigned INDEX_W   = index_w(NUM_LINES),
  localparam int unsigned OFFSET_W  = offset_w(LINE_WORDS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [INDEX_W-1:0]                  rd_idx_i,
  output logic                                rd_valid_o,
  output logic                                rd_dirty_o,
  output logic [TAG_W-1:0]                    rd_tag_o,
  output logic [LINE_WORDS-1:0][DATA_W-1:0]   rd_line_o,
  input  logic [INDEX_W-1:0]                  wr_idx_i,
  input  logic                                word_we_i,
  input  logic [OFFSET_W-1:0]                 wr_off_i,
  input  logic [DATA_W-1:0]                   wr_word_i,
  input  logic                                line_we_i,
  input  logic [TAG_W-1:0]                    wr_tag_i,
  input  logic [LINE_WORDS-1:0][DATA_W-1:0]   wr_line_i
);

  logic [NUM_LINES-1:0]              valid_q;
  logic [NUM_LINES-1:0]              dirty_q;
  logic [TAG_W-1:0]                  tag_q  [NUM_LINES];
  logic [LINE_WORDS-1:0][DATA_W-1:0] data_q [NUM_LINES];

  // Combinational read of the selected line.
  always_comb begin
    rd_valid_o = valid_q[rd_idx_i];
    rd_dirty_o = dirty_q[rd_idx_i];
    rd_tag_o   = tag_q[rd_idx_i];
    rd_line_o  = data_q[rd_idx_i];
  end

  // Valid/dirty bits: cleared by reset, set by refill / store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data storage; not reset, qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (line_we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end else if (word_we_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_word_i;
    end
  end

endmodule

// File: rtl/d_cache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// Hits are served in one cycle; misses run EVICT (if dirty) then FILL.
module d_cache_ctrl import cache_pkg::*; #(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned NUM_LINES  = DEF_NUM_LINES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         d_cache_miss,
  output logic                         enable_write_from_cache_to_memory,
  output logic                         mem_req,
  output logic                         mem_write,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [LINE_WORDS*DATA_W-1:0] mem_wline,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_rline,
  input  logic                         mem_ready
);

  localparam int unsigned OFFSET_W   = offset_w(LINE_WORDS);
  localparam int unsigned INDEX_W    = index_w(NUM_LINES);
  localparam int unsigned TAG_W      = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
  localparam int unsigned BYTE_OFF_W = OFFSET_W + 2;
  localparam int unsigned LINE_W     = LINE_WORDS * DATA_W;

  // Request address fields.
  logic [OFFSET_W-1:0] req_off;
  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                addr_lsb_unused;

  assign req_off         = req_addr[OFFSET_W+1:2];
  assign req_idx         = req_addr[BYTE_OFF_W +: INDEX_W];
  assign req_tag         = req_addr[ADDR_W-1 -: TAG_W];
  assign addr_lsb_unused = ^req_addr[1:0];

  state_e              state_q, state_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]    req_tag_q, req_tag_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wline_q, mem_wline_d;

  logic                              miss_c;
  logic                              evict_c;
  logic                              word_we;
  logic                              line_we;
  logic [INDEX_W-1:0]                arr_idx;
  logic                              rd_valid;
  logic                              rd_dirty;
  logic [TAG_W-1:0]                  rd_tag;
  logic [LINE_WORDS-1:0][DATA_W-1:0] rd_line;
  logic                              hit;

  // In IDLE the arrays follow the request; during a miss they follow the latched index.
  assign arr_idx = (state_q == ST_IDLE) ? req_idx : idx_q;
  assign hit     = rd_valid && (rd_tag == req_tag);

  cache_line_store #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (arr_idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_idx_i   (arr_idx),
    .word_we_i  (word_we),
    .wr_off_i   (req_off),
    .wr_word_i  (req_wdata),
    .line_we_i  (line_we),
    .wr_tag_i   (req_tag_q),
    .wr_line_i  (mem_rline)
  );

  // Next-state, memory-request and stall logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    req_tag_d   = req_tag_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wline_d = mem_wline_q;
    miss_c      = 1'b0;
    evict_c     = 1'b0;
    word_we     = 1'b0;
    line_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (hit) begin
            word_we = req_write;
          end else begin
            miss_c    = 1'b1;
            idx_d     = req_idx;
            req_tag_d = req_tag;
            mem_req_d = 1'b1;
            if (rd_valid && rd_dirty) begin
              state_d     = ST_EVICT;
              mem_write_d = 1'b1;
              mem_addr_d  = {rd_tag, req_idx, BYTE_OFF_W'(0)};
              mem_wline_d = rd_line;
            end else begin
              state_d     = ST_FILL;
              mem_write_d = 1'b0;
              mem_addr_d  = {req_tag, req_idx, BYTE_OFF_W'(0)};
            end
          end
        end
      end
      ST_EVICT: begin
        evict_c = 1'b1;
        if (mem_ready) begin
          state_d     = ST_FILL;
          mem_write_d = 1'b0;
          mem_addr_d  = {req_tag_q, idx_q, BYTE_OFF_W'(0)};
        end
      end
      ST_FILL: begin
        miss_c = 1'b1;
        if (mem_ready) begin
          line_we     = 1'b1;
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and memory-interface registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      req_tag_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wline_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      req_tag_q   <= req_tag_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wline_q <= mem_wline_d;
    end
  end

  assign rd_data                           = rd_line[req_off];
  assign d_cache_miss                      = miss_c;
  assign enable_write_from_cache_to_memory = evict_c;
  assign mem_req                           = mem_req_q;
  assign mem_write                         = mem_write_q;
  assign mem_addr                          = mem_addr_q;
  assign mem_wline                         = mem_wline_q;

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Randomized bench for d_cache_ctrl against an array-level cache/memory model.
module tb_d_cache_ctrl;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rd_data;
  logic        d_cache_miss;
  logic        ewr;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  line_t       mem_wline;
  line_t       mem_rline;
  logic        mem_ready;

  always #5 clk = ~clk;

  d_cache_ctrl dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .req_valid                         (req_valid),
    .req_write                         (req_write),
    .req_addr                          (req_addr),
    .req_wdata                         (req_wdata),
    .rd_data                           (rd_data),
    .d_cache_miss                      (d_cache_miss),
    .enable_write_from_cache_to_memory (ewr),
    .mem_req                           (mem_req),
    .mem_write                         (mem_write),
    .mem_addr                          (mem_addr),
    .mem_wline                         (mem_wline),
    .mem_rline                         (mem_rline),
    .mem_ready                         (mem_ready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    line_t       line;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] tb_mem [int unsigned];
  int          lat = 5;
  int          spur_req = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference cache: 4 lines of 4 words, 64-byte tag granularity.
  bit          mv [4];
  bit          md [4];
  int unsigned mt [4];
  line_t       ml [4];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (tb_mem.exists(a)) return tb_mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic line_t mem_line(input logic [31:0] base);
    line_t l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_rd(base + 32'(4 * w));
    return l;
  endfunction

  // Main-memory responder: ready after `lat` cycles of mem_req, logs each transaction.
  initial begin
    int cnt = 0;
    int spur_done = 0;
    mem_ready = 1'b0;
    mem_rline = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end
      if (spur_req != spur_done) begin
        spur_done = spur_req;
        mem_ready = 1'b1;
        mem_rline = {$urandom, $urandom, $urandom, $urandom};
      end else if (rst_n && mem_req) begin
        cnt++;
        if (cnt >= lat) begin
          txn_t t;
          t.wr   = mem_write;
          t.addr = mem_addr;
          t.line = mem_wline;
          if (mem_write) begin
            for (int w = 0; w < 4; w++) tb_mem[mem_addr + 32'(4 * w)] = mem_wline[w*32 +: 32];
          end else begin
            mem_rline = mem_line(mem_addr);
          end
          log_q.push_back(t);
          mem_ready = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // One load/store held until the stall clears, checked against the model.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned idx   = (addr >> 4) % 4;
    int unsigned tag   = addr >> 6;
    int unsigned off   = (addr >> 2) % 4;
    bit          hit   = mv[idx] && (mt[idx] == tag);
    bit          dv    = !hit && mv[idx] && md[idx];
    logic [31:0] base  = addr & 32'hFFFF_FFF0;
    logic [31:0] vaddr = (mt[idx] << 6) | (idx << 4);
    line_t       nline = mem_line(base);
    line_t       vline = ml[idx];
    int          exp_stall = hit ? 0 : (dv ? 2 * lat + 1 : lat + 1);
    int          cyc = 0;
    int          ewr_cyc = 0;
    txn_t        t;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    check_eq("miss_same_cycle", d_cache_miss, !hit);
    while ((d_cache_miss || ewr) && cyc < 200) begin
      if (ewr) ewr_cyc++;
      check_eq("stall_exclusive", d_cache_miss && ewr, 0);
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        check_eq("mem_req_rise", mem_req, 1);
        check_eq("mem_write_first", mem_write, dv);
        check_eq("mem_addr_first", mem_addr, dv ? vaddr : base);
      end
    end
    check_eq("stall_cycles", cyc, exp_stall);
    check_eq("evict_cycles", ewr_cyc, dv ? lat : 0);
    if (!hit) begin
      ml[idx] = nline;
      mt[idx] = tag;
      mv[idx] = 1'b1;
      md[idx] = 1'b0;
      check_eq("txn_count", log_q.size(), dv ? 2 : 1);
      if (dv && log_q.size() > 0) begin
        t = log_q.pop_front();
        check_eq("evict_is_write", t.wr, 1);
        check_eq("evict_addr", t.addr, vaddr);
        check_eq("evict_line", t.line, vline);
      end
      if (log_q.size() > 0) begin
        t = log_q.pop_front();
        check_eq("fill_is_read", t.wr, 0);
        check_eq("fill_addr", t.addr, base);
      end
    end else begin
      check_eq("hit_no_txn", log_q.size(), 0);
    end
    if (wr) begin
      ml[idx][off*32 +: 32] = wdata;
      md[idx] = 1'b1;
    end else begin
      check_eq("rd_data", rd_data, ml[idx][off*32 +: 32]);
    end
    @(negedge clk);
    req_valid = 1'b0;
    log_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = 0;
      ml[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_write", mem_write, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wline", mem_wline, 0);
    check_eq("rst_miss", d_cache_miss, 0);
    check_eq("rst_ewr", ewr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold load, load hit, store hit, then dirty eviction to the same index.
    lat = 5;
    access(1'b0, 32'h100, 32'h0);
    access(1'b0, 32'h104, 32'h0);
    access(1'b1, 32'h108, 32'hDEAD_BEEF);
    access(1'b0, 32'h140, 32'h0);
    check_eq("evicted_word2", mem_rd(32'h108), 32'hDEAD_BEEF);

    // Request withdrawn during a clean fill: the fill still completes.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h110;
    k = 0;
    while (!(mem_req && !mem_write) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("fill_started", mem_req && !mem_write, 1);
    req_valid = 1'b0;
    k = 0;
    while (mem_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("fill_finished", mem_req, 0);
    check_eq("withdrawn_txns", log_q.size(), 1);
    log_q.delete();
    mv[1] = 1'b1;
    md[1] = 1'b0;
    mt[1] = 32'h110 >> 6;
    ml[1] = mem_line(32'h110);
    @(negedge clk);
    access(1'b0, 32'h118, 32'h0);

    // Reset pulse during an eviction drops everything.
    access(1'b1, 32'h144, 32'h1234_5678);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h100;
    @(negedge clk);
    check_eq("evict_entered", ewr, 1);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_mid_mem_req", mem_req, 0);
    check_eq("rst_mid_miss", d_cache_miss, 0);
    check_eq("rst_mid_ewr", ewr, 0);
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    log_q.delete();
    @(negedge clk);
    access(1'b0, 32'h104, 32'h0);

    // Spurious mem_ready while idle must not disturb state or arrays.
    spur_req++;
    repeat (3) @(negedge clk);
    check_eq("spurious_no_req", mem_req, 0);
    access(1'b0, 32'h108, 32'h0);
    access(1'b0, 32'h104, 32'h0);

    // Random loads/stores over a small tag set to mix hits, clean and dirty misses.
    for (int n = 0; n < 80; n++) begin
      int unsigned tg = $urandom_range(4, 7);
      int unsigned ix = $urandom_range(0, 3);
      int unsigned of = $urandom_range(0, 3);
      lat = $urandom_range(1, 6);
      access(bit'($urandom_range(0, 1)), 32'((tg << 6) | (ix << 4) | (of << 2)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/d_cache_ctrl.md
Name: d_cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller for the memory stage.
- Serves one load/store per cycle on a hit. On a miss it runs an evict/refill sequence against main memory.
- Produces `d_cache_miss` and `enable_write_from_cache_to_memory`, the memory-stage stall sources consumed by the pipeline stall controller.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.
- LINE_WORDS, 4, words per line (power of 2).
- NUM_LINES, 4, number of lines (power of 2).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  memory stage holds a load/store this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address, word-aligned.
- req_wdata  in  DATA_W  store data.
- rd_data  out  DATA_W  load data. Combinational; valid on a hit.
- d_cache_miss  out  1  stall request: refill in progress or miss detected.
- enable_write_from_cache_to_memory  out  1  stall request: dirty-line write-back in progress.
- mem_req  out  1  memory transaction request, held until mem_ready.
- mem_write  out  1  1 = line write-back, 0 = line read.
- mem_addr  out  ADDR_W  line-aligned address.
- mem_wline  out  LINE_WORDS*DATA_W  evicted line data.
- mem_rline  in  LINE_WORDS*DATA_W  refill line data, valid with mem_ready.
- mem_ready  in  1  one-cycle completion pulse.

Behaviour:
- **Address split:**
  - offset = req_addr[log2(LINE_WORDS)+1:2].
  - index = next log2(NUM_LINES) bits.
  - tag = remaining upper bits.
- **Hit definition:** hit = valid[index] && tag_arr[index] == tag.
- **Reset:** state IDLE; valid and dirty arrays cleared; all outputs 0 (mem_req, mem_write, mem_addr, mem_wline, d_cache_miss, enable_write_from_cache_to_memory). Data and tag arrays are not reset.
- **FSM states:** IDLE, EVICT, FILL.
- **IDLE:**
  - req_valid && hit && !req_write: rd_data = line word, same cycle. No stall.
  - req_valid && hit && req_write: the addressed word is written and dirty set at the clock edge. No stall.
  - req_valid && !hit: the victim tag and index plus the request tag are latched. d_cache_miss = 1 combinationally in the same cycle so the pipeline freezes before the edge.
    - Victim valid and dirty: go to EVICT.
    - Otherwise: go to FILL.
- **EVICT:**
  - mem_req = 1, mem_write = 1, mem_addr = {victim tag, index, 0}, mem_wline = victim line.
  - enable_write_from_cache_to_memory = 1; d_cache_miss = 0.
  - On mem_ready: go to FILL.
- **FILL:**
  - mem_req = 1, mem_write = 0, mem_addr = {latched tag, index, 0}.
  - d_cache_miss = 1.
  - On mem_ready: write mem_rline to the line, set tag, valid = 1, dirty = 0; return to IDLE.
  - The stalled request re-evaluates as a hit on the next cycle. Stores complete then, with no store merge during refill.
- **Latency:**
  - Clean miss: mem latency + 1 cycle stall.
  - Dirty miss: two memory latencies + 1.
- **Output timing:** mem_req and mem_write are registered (rise one cycle after miss detection).
- **Exclusivity:** d_cache_miss and enable_write_from_cache_to_memory are never both 1 outside IDLE.
- **Request withdrawn mid-miss (req_valid drops, e.g. branch flush):** the sequence in progress completes; the filled line stays valid. No abort of a memory transaction.
- **mem_ready outside EVICT/FILL:** ignored.
- **Reset mid-operation:** returns to IDLE, drops mem_req, invalidates all lines. Dirty data is lost, by design.
- **Same index, different tag, back-to-back:** each access is a fresh miss (thrash). No corruption.

Decomposition:
- **Shared package `cache_pkg`:**
  - FSM state enum.
  - Address field width functions/constants (OFFSET_W, INDEX_W, TAG_W).
  - Line type.
- **Sub-module `cache_line_store`:** tag/valid/dirty/data arrays with one combinational read port and one synchronous write port (word write or full-line write). The controller FSM stays in `d_cache_ctrl`.

Test Plan:
1. **Reset, then load 0x100:** d_cache_miss = 1 same cycle; mem_req rises next cycle with mem_write = 0, mem_addr = 0x100. After mem_ready (latency 5), d_cache_miss falls and rd_data = word 0 of mem_rline.
2. **Load hit:** after scenario 1, load 0x104 -> no stall, rd_data = word 1 of the refilled line.
3. **Store 0xDEADBEEF to 0x108 (hit), then load 0x140 (same index 0, new tag):**
   - enable_write_from_cache_to_memory = 1 with mem_write = 1, mem_addr = 0x100, word 2 of mem_wline = 0xDEADBEEF.
   - Then FILL at mem_addr = 0x140 with d_cache_miss = 1.
4. **Clean miss, req_valid dropped during FILL:** FILL completes; the line is valid; a later load to the same line hits with no stall.
5. **rst_n low for one cycle during EVICT:** mem_req = 0 and both stall outputs = 0 the next cycle. A load to the prior hit address 0x104 misses.
6. **Spurious mem_ready in IDLE:** no state change, no array write.
